// File: rtl/mem_access_if.sv
// Data-bus bundle between the memory-access stage (master) and the data memory (slave).
interface mem_access_if;
   logic        dbus_req_o;
   logic        dbus_we_o;
   logic [31:0] dbus_addr_o;
   logic [31:0] dbus_wdata_o;
   logic [3:0]  dbus_strb_o;
   logic        dbus_ack_i;
   logic [31:0] dbus_rdata_i;

   modport master (
      output dbus_req_o, dbus_we_o, dbus_addr_o, dbus_wdata_o, dbus_strb_o,
      input  dbus_ack_i, dbus_rdata_i
   );

   modport slave (
      input  dbus_req_o, dbus_we_o, dbus_addr_o, dbus_wdata_o, dbus_strb_o,
      output dbus_ack_i, dbus_rdata_i
   );
endinterface

// File: rtl/mem_access.sv
// RISC-V memory-access stage: data-bus load/store handshake, load alignment/extension,
// and one registered writeback record per accepted instruction.
module mem_access #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ex_valid_i,
   output logic         mem_ready_o,
   input  logic [31:0]  alu_result_i,
   input  logic [31:0]  mem_write_data_i,
   input  logic         ctrl_mem_read_i,
   input  logic         ctrl_mem_write_i,
   input  logic [1:0]   ctrl_mem_size_i,
   input  logic         ctrl_mem_unsigned_i,
   input  logic         ctrl_reg_write_i,
   input  logic [4:0]   rd_addr_i,
   mem_access_if.master dbus,
   output logic         wb_valid_o,
   output logic         wb_reg_write_o,
   output logic [4:0]   wb_rd_addr_o,
   output logic [31:0]  wb_data_o,
   output logic         misalign_o,
   output logic         bus_err_o
);
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   typedef enum logic {S_IDLE, S_BUS} state_t;

   state_t             r_state, w_state_nxt;
   logic               r_req, w_req_nxt;
   logic               r_we, w_we_nxt;
   logic [31:0]        r_addr, w_addr_nxt;
   logic [31:0]        r_wdata, w_wdata_nxt;
   logic [3:0]         r_strb, w_strb_nxt;
   logic               r_wb_valid, w_wb_valid_nxt;
   logic               r_wb_rw, w_wb_rw_nxt;
   logic [4:0]         r_wb_rd, w_wb_rd_nxt;
   logic [31:0]        r_wb_data, w_wb_data_nxt;
   logic               r_misalign, w_misalign_nxt;
   logic               r_bus_err, w_bus_err_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [1:0]         r_off, w_off_nxt;
   logic [1:0]         r_size, w_size_nxt;
   logic               r_uns, w_uns_nxt;
   logic [4:0]         r_rd, w_rd_nxt;
   logic               r_rw, w_rw_nxt;
   logic               r_load, w_load_nxt;

   logic               w_is_mem, w_is_store, w_bad;
   logic [3:0]         w_st_strb;
   logic [31:0]        w_st_wdata, w_shift, w_load_data;
   logic [CNT_W-1:0]   w_cnt_inc;
   logic               w_timeout;

   assign mem_ready_o = (r_state == S_IDLE);
   assign w_is_mem    = ctrl_mem_read_i | ctrl_mem_write_i;
   assign w_is_store  = ctrl_mem_write_i & ~ctrl_mem_read_i;
   assign w_cnt_inc   = r_cnt + CNT_W'(1);
   assign w_timeout   = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

   // Store lane placement and alignment check from the incoming address
   always_comb begin
      w_st_strb  = 4'b1111;
      w_st_wdata = mem_write_data_i;
      w_bad      = 1'b1;
      case (ctrl_mem_size_i)
         SZ_B: begin
            w_st_strb  = 4'b0001 << alu_result_i[1:0];
            w_st_wdata = {4{mem_write_data_i[7:0]}};
            w_bad      = 1'b0;
         end
         SZ_H: begin
            w_st_strb  = 4'b0011 << alu_result_i[1:0];
            w_st_wdata = {2{mem_write_data_i[15:0]}};
            w_bad      = alu_result_i[0];
         end
         SZ_W:    w_bad = (alu_result_i[1:0] != 2'b00);
         default: w_bad = 1'b1;
      endcase
   end

   // Load lane extraction and extension
   always_comb begin
      w_shift = dbus.dbus_rdata_i >> {r_off, 3'b000};
      case (r_size)
         SZ_B:    w_load_data = r_uns ? {24'd0, w_shift[7:0]} : {{24{w_shift[7]}}, w_shift[7:0]};
         SZ_H:    w_load_data = r_uns ? {16'd0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
         default: w_load_data = w_shift;
      endcase
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_req_nxt      = r_req;
      w_we_nxt       = r_we;
      w_addr_nxt     = r_addr;
      w_wdata_nxt    = r_wdata;
      w_strb_nxt     = r_strb;
      w_wb_valid_nxt = 1'b0;
      w_wb_rw_nxt    = r_wb_rw;
      w_wb_rd_nxt    = r_wb_rd;
      w_wb_data_nxt  = r_wb_data;
      w_misalign_nxt = 1'b0;
      w_bus_err_nxt  = 1'b0;
      w_cnt_nxt      = r_cnt;
      w_off_nxt      = r_off;
      w_size_nxt     = r_size;
      w_uns_nxt      = r_uns;
      w_rd_nxt       = r_rd;
      w_rw_nxt       = r_rw;
      w_load_nxt     = r_load;
      case (r_state)
         S_IDLE: begin
            if (ex_valid_i) begin
               w_wb_rd_nxt = rd_addr_i;
               if (!w_is_mem) begin
                  w_wb_valid_nxt = 1'b1;
                  w_wb_rw_nxt    = ctrl_reg_write_i;
                  w_wb_data_nxt  = alu_result_i;
               end else if (w_bad) begin
                  w_wb_valid_nxt = 1'b1;
                  w_wb_rw_nxt    = 1'b0;
                  w_wb_data_nxt  = alu_result_i;
                  w_misalign_nxt = 1'b1;
               end else begin
                  w_state_nxt = S_BUS;
                  w_req_nxt   = 1'b1;
                  w_we_nxt    = w_is_store;
                  w_addr_nxt  = {alu_result_i[31:2], 2'b00};
                  w_wdata_nxt = w_is_store ? w_st_wdata : 32'd0;
                  w_strb_nxt  = w_is_store ? w_st_strb : 4'd0;
                  w_cnt_nxt   = '0;
                  w_off_nxt   = alu_result_i[1:0];
                  w_size_nxt  = ctrl_mem_size_i;
                  w_uns_nxt   = ctrl_mem_unsigned_i;
                  w_rd_nxt    = rd_addr_i;
                  w_rw_nxt    = ctrl_reg_write_i;
                  w_load_nxt  = ctrl_mem_read_i;
               end
            end
         end
         S_BUS: begin
            // Ack takes priority over a timeout on the same edge
            if (dbus.dbus_ack_i || w_timeout) begin
               w_state_nxt    = S_IDLE;
               w_req_nxt      = 1'b0;
               w_we_nxt       = 1'b0;
               w_addr_nxt     = 32'd0;
               w_wdata_nxt    = 32'd0;
               w_strb_nxt     = 4'd0;
               w_wb_valid_nxt = 1'b1;
               w_wb_rd_nxt    = r_rd;
               w_wb_rw_nxt    = 1'b0;
               w_wb_data_nxt  = 32'd0;
               if (!dbus.dbus_ack_i) begin
                  w_bus_err_nxt = 1'b1;
               end else if (r_load) begin
                  w_wb_rw_nxt   = r_rw;
                  w_wb_data_nxt = w_load_data;
               end
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_req      <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= 32'd0;
         r_wdata    <= 32'd0;
         r_strb     <= 4'd0;
         r_wb_valid <= 1'b0;
         r_wb_rw    <= 1'b0;
         r_wb_rd    <= 5'd0;
         r_wb_data  <= 32'd0;
         r_misalign <= 1'b0;
         r_bus_err  <= 1'b0;
         r_cnt      <= '0;
         r_off      <= 2'd0;
         r_size     <= 2'd0;
         r_uns      <= 1'b0;
         r_rd       <= 5'd0;
         r_rw       <= 1'b0;
         r_load     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_req      <= w_req_nxt;
         r_we       <= w_we_nxt;
         r_addr     <= w_addr_nxt;
         r_wdata    <= w_wdata_nxt;
         r_strb     <= w_strb_nxt;
         r_wb_valid <= w_wb_valid_nxt;
         r_wb_rw    <= w_wb_rw_nxt;
         r_wb_rd    <= w_wb_rd_nxt;
         r_wb_data  <= w_wb_data_nxt;
         r_misalign <= w_misalign_nxt;
         r_bus_err  <= w_bus_err_nxt;
         r_cnt      <= w_cnt_nxt;
         r_off      <= w_off_nxt;
         r_size     <= w_size_nxt;
         r_uns      <= w_uns_nxt;
         r_rd       <= w_rd_nxt;
         r_rw       <= w_rw_nxt;
         r_load     <= w_load_nxt;
      end
   end

   assign dbus.dbus_req_o   = r_req;
   assign dbus.dbus_we_o    = r_we;
   assign dbus.dbus_addr_o  = r_addr;
   assign dbus.dbus_wdata_o = r_wdata;
   assign dbus.dbus_strb_o  = r_strb;
   assign wb_valid_o        = r_wb_valid;
   assign wb_reg_write_o    = r_wb_rw;
   assign wb_rd_addr_o      = r_wb_rd;
   assign wb_data_o         = r_wb_data;
   assign misalign_o        = r_misalign;
   assign bus_err_o         = r_bus_err;
endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: expected writeback records are queued by the stimulus
// and consumed by an independent monitor; bus-side behaviour is checked inline.
module tb_mem_access;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ex_valid = 1'b0;
   logic        mem_ready;
   logic [31:0] alu_result = '0;
   logic [31:0] wdata_in = '0;
   logic        c_rd = 1'b0, c_wr = 1'b0, c_uns = 1'b0, c_rw = 1'b0;
   logic [1:0]  c_size = '0;
   logic [4:0]  rd_addr = '0;
   logic        wb_valid, wb_rw, misalign, bus_err;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic        misalign;
      logic        bus_err;
      logic        rw;
      logic        chk_rd;
      logic [4:0]  rd;
      logic        chk_data;
      logic [31:0] data;
   } wb_exp_t;

   wb_exp_t sb_q[$];

   mem_access_if bus ();

   mem_access #(.TIMEOUT_CYCLES(4)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .ex_valid_i          (ex_valid),
      .mem_ready_o         (mem_ready),
      .alu_result_i        (alu_result),
      .mem_write_data_i    (wdata_in),
      .ctrl_mem_read_i     (c_rd),
      .ctrl_mem_write_i    (c_wr),
      .ctrl_mem_size_i     (c_size),
      .ctrl_mem_unsigned_i (c_uns),
      .ctrl_reg_write_i    (c_rw),
      .rd_addr_i           (rd_addr),
      .dbus                (bus.master),
      .wb_valid_o          (wb_valid),
      .wb_reg_write_o      (wb_rw),
      .wb_rd_addr_o        (wb_rd),
      .wb_data_o           (wb_data),
      .misalign_o          (misalign),
      .bus_err_o           (bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_wb(input logic mis, input logic berr, input logic rw, input logic chk_rd,
                            input logic [4:0] rd, input logic chk_data, input logic [31:0] data);
      wb_exp_t e;
      e.misalign = mis; e.bus_err = berr; e.rw = rw; e.chk_rd = chk_rd;
      e.rd = rd; e.chk_data = chk_data; e.data = data;
      sb_q.push_back(e);
   endtask

   // Presents one instruction; returns 1ns after its acceptance edge
   task automatic send(input logic rd_, input logic wr_, input logic [1:0] sz, input logic uns,
                       input logic rw, input logic [4:0] rd, input logic [31:0] addr,
                       input logic [31:0] wd);
      ex_valid = 1'b1; c_rd = rd_; c_wr = wr_; c_size = sz; c_uns = uns; c_rw = rw;
      rd_addr = rd; alu_result = addr; wdata_in = wd;
      @(posedge clk); #1;
      ex_valid = 1'b0; c_rd = 1'b0; c_wr = 1'b0; c_rw = 1'b0;
   endtask

   // Drives ack after 'waits' idle bus cycles, checking the held request each cycle
   task automatic bus_cycle(input int waits, input logic [31:0] rdata, input logic [31:0] exp_addr,
                            input logic exp_we, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wdata, input string tag);
      for (int i = 0; i <= waits; i++) begin
         if (i == waits) begin
            bus.dbus_ack_i = 1'b1;
            bus.dbus_rdata_i = rdata;
         end
         @(negedge clk);
         chk({tag, " req"}, 32'(bus.dbus_req_o), 32'd1);
         chk({tag, " ready_low"}, 32'(mem_ready), 32'd0);
         chk({tag, " addr"}, bus.dbus_addr_o, exp_addr);
         chk({tag, " we"}, 32'(bus.dbus_we_o), 32'(exp_we));
         chk({tag, " strb"}, 32'(bus.dbus_strb_o), 32'(exp_strb));
         if (exp_we) chk({tag, " wdata"}, bus.dbus_wdata_o, exp_wdata);
         @(posedge clk); #1;
      end
      bus.dbus_ack_i = 1'b0;
      bus.dbus_rdata_i = 32'hDEAD_BEEF;
      @(negedge clk);
      chk({tag, " req_drop"}, 32'(bus.dbus_req_o), 32'd0);
      chk({tag, " ready_back"}, 32'(mem_ready), 32'd1);
      @(posedge clk); #1;
   endtask

   // Writeback monitor: every pulse must match the oldest queued expectation
   initial begin
      forever begin
         @(negedge clk);
         if (wb_valid || misalign || bus_err) begin
            if (sb_q.size() == 0) begin
               chk("wb_unexpected", {29'd0, wb_valid, misalign, bus_err}, 32'd0);
            end else begin
               wb_exp_t e;
               e = sb_q.pop_front();
               chk("wb_valid", 32'(wb_valid), 32'd1);
               chk("wb_misalign", 32'(misalign), 32'(e.misalign));
               chk("wb_bus_err", 32'(bus_err), 32'(e.bus_err));
               chk("wb_reg_write", 32'(wb_rw), 32'(e.rw));
               if (e.chk_rd) chk("wb_rd", 32'(wb_rd), 32'(e.rd));
               if (e.chk_data) chk("wb_data", wb_data, e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.dbus_ack_i = 1'b0;
      bus.dbus_rdata_i = '0;
      #12;
      chk("rst ready", 32'(mem_ready), 32'd1);
      chk("rst req", 32'(bus.dbus_req_o), 32'd0);
      chk("rst wb", {26'd0, wb_valid, wb_rw, misalign, bus_err, 2'b00}, 32'd0);
      chk("rst wb_data", wb_data, 32'd0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;

      // ALU op
      expect_wb(0, 0, 1, 1, 5'd5, 1, 32'h0000_1234);
      send(0, 0, 2'b10, 0, 1, 5'd5, 32'h0000_1234, 32'h0);
      @(negedge clk);
      chk("alu no req", 32'(bus.dbus_req_o), 32'd0);
      @(posedge clk); #1;

      // Ack while idle is ignored
      bus.dbus_ack_i = 1'b1;
      @(posedge clk); #1;
      bus.dbus_ack_i = 1'b0;

      // Back-to-back ALU ops
      expect_wb(0, 0, 1, 1, 5'd1, 1, 32'h1111_0001);
      expect_wb(0, 0, 0, 1, 5'd2, 1, 32'h2222_0002);
      expect_wb(0, 0, 1, 1, 5'd3, 1, 32'h3333_0003);
      send(0, 0, 2'b00, 0, 1, 5'd1, 32'h1111_0001, 32'h0);
      send(0, 0, 2'b00, 0, 0, 5'd2, 32'h2222_0002, 32'h0);
      send(0, 0, 2'b00, 0, 1, 5'd3, 32'h3333_0003, 32'h0);

      // lb 0x103, two waits
      expect_wb(0, 0, 1, 1, 5'd7, 1, 32'hFFFF_FF80);
      send(1, 0, 2'b00, 0, 1, 5'd7, 32'h0000_0103, 32'h0);
      bus_cycle(2, 32'h80AA_BBCC, 32'h0000_0100, 0, 4'b0000, 32'h0, "lb");

      // lhu 0x202 zero-wait, then sb 0x201
      expect_wb(0, 0, 1, 1, 5'd8, 1, 32'h0000_8001);
      send(1, 0, 2'b01, 1, 1, 5'd8, 32'h0000_0202, 32'h0);
      bus_cycle(0, 32'h8001_0000, 32'h0000_0200, 0, 4'b0000, 32'h0, "lhu");
      expect_wb(0, 0, 0, 0, 5'd0, 1, 32'h0);
      send(0, 1, 2'b00, 0, 1, 5'd9, 32'h0000_0201, 32'h0000_005A);
      bus_cycle(0, 32'h0, 32'h0000_0200, 1, 4'b0010, 32'h5A5A_5A5A, "sb");

      // lh signed, lbu offset 1, sh upper half, sw with one wait
      expect_wb(0, 0, 1, 1, 5'd10, 1, 32'hFFFF_FFFE);
      send(1, 0, 2'b01, 0, 1, 5'd10, 32'h0000_0012, 32'h0);
      bus_cycle(1, 32'hFFFE_0000, 32'h0000_0010, 0, 4'b0000, 32'h0, "lh");
      expect_wb(0, 0, 1, 1, 5'd11, 1, 32'h0000_00F1);
      send(1, 0, 2'b00, 1, 1, 5'd11, 32'h0000_0021, 32'h0);
      bus_cycle(0, 32'h0000_F100, 32'h0000_0020, 0, 4'b0000, 32'h0, "lbu");
      expect_wb(0, 0, 0, 0, 5'd0, 1, 32'h0);
      send(0, 1, 2'b01, 0, 0, 5'd12, 32'h0000_0032, 32'h1234_ABCD);
      bus_cycle(0, 32'h0, 32'h0000_0030, 1, 4'b1100, 32'hABCD_ABCD, "sh");
      expect_wb(0, 0, 0, 0, 5'd0, 1, 32'h0);
      send(0, 1, 2'b10, 0, 0, 5'd13, 32'h0000_0040, 32'hCAFE_F00D);
      bus_cycle(1, 32'h0, 32'h0000_0040, 1, 4'b1111, 32'hCAFE_F00D, "sw");

      // Read and write both set behaves as a load
      expect_wb(0, 0, 1, 1, 5'd14, 1, 32'h1357_9BDF);
      send(1, 1, 2'b10, 0, 1, 5'd14, 32'h0000_0050, 32'hFFFF_FFFF);
      bus_cycle(0, 32'h1357_9BDF, 32'h0000_0050, 0, 4'b0000, 32'h0, "rw_load");

      // Misaligned lw, then next op the following cycle
      expect_wb(1, 0, 0, 0, 5'd0, 0, 32'h0);
      send(1, 0, 2'b10, 0, 1, 5'd15, 32'h0000_0006, 32'h0);
      chk("mis ready", 32'(mem_ready), 32'd1);
      chk("mis no req", 32'(bus.dbus_req_o), 32'd0);
      expect_wb(0, 0, 1, 1, 5'd16, 1, 32'h0000_ABCD);
      send(0, 0, 2'b00, 0, 1, 5'd16, 32'h0000_ABCD, 32'h0);

      // Illegal size
      expect_wb(1, 0, 0, 0, 5'd0, 0, 32'h0);
      send(0, 1, 2'b11, 0, 0, 5'd17, 32'h0000_0000, 32'h0);
      chk("ill no req", 32'(bus.dbus_req_o), 32'd0);
      @(posedge clk); #1;

      // Timeout: four request cycles, then bus error
      expect_wb(0, 1, 0, 0, 5'd0, 0, 32'h0);
      send(1, 0, 2'b10, 0, 1, 5'd18, 32'h0000_0300, 32'h0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("to req held", 32'(bus.dbus_req_o), 32'd1);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("to req drop", 32'(bus.dbus_req_o), 32'd0);
      chk("to ready", 32'(mem_ready), 32'd1);
      @(posedge clk); #1;

      // Ack on the timeout edge completes normally
      expect_wb(0, 0, 1, 1, 5'd19, 1, 32'h0BAD_F00D);
      send(1, 0, 2'b10, 0, 1, 5'd19, 32'h0000_0304, 32'h0);
      bus_cycle(3, 32'h0BAD_F00D, 32'h0000_0304, 0, 4'b0000, 32'h0, "to_ack");

      // Reset in the middle of a bus transaction
      send(1, 0, 2'b10, 0, 1, 5'd20, 32'h0000_0400, 32'h0);
      @(negedge clk);
      chk("mid req", 32'(bus.dbus_req_o), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("rstmid req", 32'(bus.dbus_req_o), 32'd0);
      chk("rstmid addr", bus.dbus_addr_o, 32'd0);
      chk("rstmid ready", 32'(mem_ready), 32'd1);
      chk("rstmid wb", {29'd0, wb_valid, misalign, bus_err}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk); rst = 1'b1;
      bus.dbus_ack_i = 1'b1;
      @(posedge clk); #1;
      bus.dbus_ack_i = 1'b0;
      chk("post rst ready", 32'(mem_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      expect_wb(0, 0, 1, 1, 5'd21, 1, 32'h0000_0777);
      send(0, 0, 2'b00, 0, 1, 5'd21, 32'h0000_0777, 32'h0);

      repeat (3) @(posedge clk);
      #1;
      chk("sb drained", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
